pid_core: RTL and testbench
===========================

Name: pid_core

Overview:
- Discrete PID controller that consumes the 12-bit PID sample stream from the timing/mux unit (data_pid_out / enable_pid) and produces a 12-bit actuator command.
- Uses one shared signed multiplier, sequenced by a small FSM.
- Fixed latency of 5 cycles per accepted sample.
- Gains are static configuration inputs in signed Q8.8 format.

Parameters:
- DW, 12: sample, setpoint and output width.
- GW, 16: gain width, signed Q(GW-FRAC).FRAC.
- FRAC, 8: fractional bits of the gains; the final right-shift amount.
- ACC_W, 32: width of the integrator accumulator and of the sum.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe (driven from enable_pid)
- in_ready  out  1  high when the core can accept a sample (state IDLE)
- meas  in  DW  measured value, unsigned
- setpoint  in  DW  target value, unsigned
- kp, ki, kd  in  GW each  signed gains
- clr  in  1  synchronous clear of the integrator and previous error
- out_valid  out  1  one-cycle pulse; out_data is valid
- out_data  out  DW  command, unsigned, saturated
- sat  out  1  high with out_valid when out_data was clamped
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock domain, clk. rstn is asynchronous, active-low.
- Reset values:
  - State returns to IDLE.
  - out_valid=0, out_data=0, sat=0, busy=0, in_ready=1.
  - Integrator acc_i=0, e_prev=0, and all pipeline registers = 0.
- Error terms:
  - e = setpoint - meas, computed as DW+1 signed.
  - de = e - e_prev, DW+2 signed.
- FSM: IDLE -> P -> I -> D -> SUM -> OUT -> IDLE.
  - IDLE: in_valid=1 captures e; next state is P.
  - P: p = kp*e.
  - I: acc_i = sat_add(acc_i, ki*e), saturating to ±(2^(ACC_W-1)-1).
  - D: d = kd*de; e_prev <= e.
  - SUM: u = p + acc_i + d, saturating at ACC_W; then v = u >>> FRAC (arithmetic shift).
  - OUT: out_data = clamp(v, 0, 2^DW-1); sat = (v<0 or v>2^DW-1); out_valid=1 for this cycle only.
- Latency: a sample accepted at edge N gives out_valid high in the cycle after edge N+5.
- Output hold: out_data and sat hold their values until the next OUT state.
- Handshake: in_ready = (state==IDLE). An in_valid while busy is dropped. There is no queue and no error flag.
- First sample after reset or clr uses e_prev=0, so a derivative kick is expected.
- clr:
  - In IDLE: zeroes acc_i and e_prev. If in_valid is high in the same cycle, the sample is still accepted and computed on the cleared state.
  - In any other state: aborts to IDLE, zeroes state, and no out_valid is produced for that sample.
- Gains are sampled in the state that uses them. Changing a gain mid-computation affects only the terms computed after the change.
- Multiplication: one GW x (DW+2) signed multiplier, muxed by state. Products are sign-extended to ACC_W.

Optional Feature:
- Macro: PID_ANTIWINDUP_EN.
- When defined: in state I, acc_i is not updated if the previous output had sat=1 and the sign of ki*e would push further into that saturation (conditional integration). The decision uses the registered sat and the sign of v from the previous sample.
- When undefined: acc_i always integrates, limited only by its own saturation.

Decomposition:
- Package pid_pkg holds:
  - state enum (IDLE, P, I, D, SUM, OUT);
  - default widths DW/GW/FRAC/ACC_W;
  - constants ACC_MAX and ACC_MIN;
  - a saturating-add function.
- Sub-module pid_sat: signed saturate/clamp from ACC_W to an unsigned DW range, emitting the sat flag. It is used in OUT and reusable by future stages.

Test Plan:
- Proportional only: kp=0x0100, ki=kd=0, setpoint=2000, meas=1000 -> out_data=1000, sat=0, 5 cycles after accept.
- Negative clamp: kp=0x0100, setpoint=1000, meas=2000 -> out_data=0, sat=1. Same with kp=0x0800, setpoint=3000, meas=0 -> out_data=4095, sat=1.
- Integrator: kp=kd=0, ki=0x0080, e=100 over three samples -> out_data=50, 100, 150. Assert clr, then one sample -> 50.
- Derivative: kd=0x0100, kp=ki=0, e=100 then e=100 -> outputs 100, 0. Then e=40 -> 0 with sat=1 (v=-60).
- Busy drop: assert in_valid during states P..OUT -> exactly one out_valid, in_ready=0 while busy, and acc_i reflects a single update.
- Reset/abort: drop rstn, and separately assert clr, during state D -> no out_valid. After reset: out_data=0, busy=0, and the next sample behaves as the first sample.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, FSM state type and saturating arithmetic for pid_core.
`default_nettype none

package pid_pkg;

  localparam int DW    = 12;
  localparam int GW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 32;

  // Symmetric range: the most negative code is never produced.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P    = 3'd1,
    ST_I    = 3'd2,
    ST_D    = 3'd3,
    ST_SUM  = 3'd4,
    ST_OUT  = 3'd5
  } pid_state_e;

  function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [ACC_W+1:0] s);
    logic signed [ACC_W+1:0] hi;
    logic signed [ACC_W+1:0] lo;
    hi = $signed({2'b00, ACC_MAX});
    lo = $signed({2'b11, ACC_MIN});
    if (s > hi) return ACC_MAX;
    if (s < lo) return ACC_MIN;
    return s[ACC_W-1:0];
  endfunction

  // Three-term sum evaluated at full precision, then clamped once.
  function automatic logic signed [ACC_W-1:0] sat_add3(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b,
                                                       input logic signed [ACC_W-1:0] c);
    logic signed [ACC_W+1:0] s;
    s = $signed({{2{a[ACC_W-1]}}, a}) + $signed({{2{b[ACC_W-1]}}, b})
      + $signed({{2{c[ACC_W-1]}}, c});
    return sat_clip(s);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    return sat_add3(a, b, '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pid_core_if.sv
// pid_core_if: sample/gain inputs and command outputs of pid_core, with master/slave views.
`default_nettype none

interface pid_core_if #(
  parameter int DW = 12,
  parameter int GW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic        [DW-1:0] meas;
  logic        [DW-1:0] setpoint;
  logic signed [GW-1:0] kp;
  logic signed [GW-1:0] ki;
  logic signed [GW-1:0] kd;
  logic                 clr;
  logic                 out_valid;
  logic        [DW-1:0] out_data;
  logic                 sat;
  logic                 busy;

  modport slave (
    input  in_valid, meas, setpoint, kp, ki, kd, clr,
    output in_ready, out_valid, out_data, sat, busy
  );

  modport master (
    output in_valid, meas, setpoint, kp, ki, kd, clr,
    input  in_ready, out_valid, out_data, sat, busy
  );
endinterface

`default_nettype wire

// File: rtl/pid_sat.sv
// pid_sat: clamps a signed ACC_W value into the unsigned DW range and flags clamping.
`default_nettype none

module pid_sat #(
  parameter int ACC_W = 32,
  parameter int DW    = 12
) (
  input  wire logic signed [ACC_W-1:0] i_v,
  output logic             [DW-1:0]    o_data,
  output logic                         o_sat
);

  always_comb begin
    o_data = i_v[DW-1:0];
    o_sat  = 1'b0;
    if (i_v[ACC_W-1]) begin
      o_data = '0;
      o_sat  = 1'b1;
    end else if (|i_v[ACC_W-2:DW]) begin
      o_data = '1;
      o_sat  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pid_core.sv
// pid_core: discrete PID with one shared signed multiplier, 5-cycle latency per sample.
// Optional macro PID_ANTIWINDUP_EN enables conditional integration.
`default_nettype none

module pid_core
  import pid_pkg::*;
#(
  parameter int DW    = pid_pkg::DW,
  parameter int GW    = pid_pkg::GW,
  parameter int FRAC  = pid_pkg::FRAC,
  parameter int ACC_W = pid_pkg::ACC_W
) (
  input  wire logic  clk,
  input  wire logic  rstn,
  pid_core_if.slave  bus
);

  localparam int PW = GW + DW + 2;

  pid_state_e r_state;
  pid_state_e w_next;

  logic signed [DW:0]      r_e;
  logic signed [DW:0]      r_eprev;
  logic signed [ACC_W-1:0] r_p;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_d;
  logic signed [ACC_W-1:0] r_v;
  logic                    r_out_valid;
  logic        [DW-1:0]    r_out_data;
  logic                    r_sat;

  logic signed [DW:0]      w_e;
  logic signed [DW+1:0]    w_de;
  logic signed [GW-1:0]    w_mul_a;
  logic signed [DW+1:0]    w_mul_b;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_u;
  logic        [DW-1:0]    w_sat_data;
  logic                    w_sat_flag;
  logic                    w_integrate;
  logic                    w_abort;
  logic                    w_in_ready;
  logic                    w_busy;

  assign w_e     = $signed({1'b0, bus.setpoint}) - $signed({1'b0, bus.meas});
  assign w_de    = $signed({r_e[DW], r_e}) - $signed({r_eprev[DW], r_eprev});
  assign w_abort = bus.clr && (r_state != ST_IDLE);

  // Shared multiplier: the operand pair is selected by the term being computed.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      ST_P: begin w_mul_a = bus.kp; w_mul_b = {r_e[DW], r_e}; end
      ST_I: begin w_mul_a = bus.ki; w_mul_b = {r_e[DW], r_e}; end
      ST_D: begin w_mul_a = bus.kd; w_mul_b = w_de;           end
      default: ;
    endcase
  end

  assign w_prod     = w_mul_a * w_mul_b;
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_u        = sat_add3(r_p, r_acc, r_d);

`ifdef PID_ANTIWINDUP_EN
  // Hold the integrator while the last output was clamped and this term pushes the same way.
  assign w_integrate = !(r_sat &&
                         (( r_v[ACC_W-1] &&  w_prod_ext[ACC_W-1]) ||
                          (!r_v[ACC_W-1] && (r_v != '0) &&
                           !w_prod_ext[ACC_W-1] && (w_prod_ext != '0))));
`else
  assign w_integrate = 1'b1;
`endif

  pid_sat #(.ACC_W(ACC_W), .DW(DW)) u_sat (
    .i_v    (r_v),
    .o_data (w_sat_data),
    .o_sat  (w_sat_flag)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid) w_next = ST_P;
      ST_P:    w_next = ST_I;
      ST_I:    w_next = ST_D;
      ST_D:    w_next = ST_SUM;
      ST_SUM:  w_next = ST_OUT;
      ST_OUT:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_comb begin
    w_in_ready = (r_state == ST_IDLE);
    w_busy     = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_e         <= '0;
      r_eprev     <= '0;
      r_p         <= '0;
      r_acc       <= '0;
      r_d         <= '0;
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_abort) begin
        r_e     <= '0;
        r_eprev <= '0;
        r_p     <= '0;
        r_acc   <= '0;
        r_d     <= '0;
        r_v     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.clr) begin
              r_acc   <= '0;
              r_eprev <= '0;
            end
            if (bus.in_valid) r_e <= w_e;
          end
          ST_P: r_p <= w_prod_ext;
          ST_I: if (w_integrate) r_acc <= sat_add(r_acc, w_prod_ext);
          ST_D: begin
            r_d     <= w_prod_ext;
            r_eprev <= r_e;
          end
          ST_SUM: r_v <= w_u >>> FRAC;
          ST_OUT: begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sat_data;
            r_sat       <= w_sat_flag;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sat       = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_pid_core.sv
// tb_pid_core: directed and randomized checks of pid_core against an integer PID model.
`default_nettype none

module tb_pid_core;
  import pid_pkg::*;

  localparam longint AMAX = 64'sd2147483647;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pid_core_if #(.DW(DW), .GW(GW)) bus ();

  pid_core dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int     checks   = 0;
  int     failures = 0;
  int     g_kp, g_ki, g_kd;
  longint m_acc    = 0;
  longint m_eprev  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint clampl(input longint x, input longint lo, input longint hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // Reference: one PID update from the sample, gains and remembered state.
  task automatic model_step(input int sp, input int m, output longint ed, output longint es);
    longint e, de, p, d, u, v;
    e       = longint'(sp) - longint'(m);
    de      = e - m_eprev;
    p       = longint'(g_kp) * e;
    m_acc   = clampl(m_acc + longint'(g_ki) * e, -AMAX, AMAX);
    d       = longint'(g_kd) * de;
    m_eprev = e;
    u       = clampl(p + m_acc + d, -AMAX, AMAX);
    v       = u >>> 8;
    ed      = clampl(v, 0, 4095);
    es      = ((v < 0) || (v > 4095)) ? 1 : 0;
  endtask

  task automatic drive_sample(input int sp, input int m, input bit with_clr);
    @(posedge clk); #1;
    bus.setpoint = sp[11:0];
    bus.meas     = m[11:0];
    bus.kp       = g_kp[15:0];
    bus.ki       = g_ki[15:0];
    bus.kd       = g_kd[15:0];
    bus.clr      = with_clr;
    bus.in_valid = 1'b1;
    if (with_clr) begin
      m_acc   = 0;
      m_eprev = 0;
    end
  endtask

  // want_d < 0 selects the model's prediction; otherwise the literal values are required.
  task automatic run_sample(input string tag, input int sp, input int m, input bit hold,
                            input bit with_clr, input longint want_d, input longint want_s);
    longint ed, es, got_d, got_s;
    int lat, pulses, bad;
    drive_sample(sp, m, with_clr);
    model_step(sp, m, ed, es);
    if (want_d >= 0) begin
      ed = want_d;
      es = want_s;
    end
    @(posedge clk); #1;
    bus.clr = 1'b0;
    if (!hold) bus.in_valid = 1'b0;
    lat = -1; pulses = 0; bad = 0; got_d = -1; got_s = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k <= 4 && (bus.in_ready !== 1'b0 || bus.busy !== 1'b1)) bad++;
      if (k == 5 && (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)) bad++;
      if (bus.out_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat   = k;
          got_d = longint'(bus.out_data);
          got_s = longint'(bus.sat);
        end
      end
      if (k == 5) bus.in_valid = 1'b0;
    end
    chk({tag, "_lat"},    lat,    5);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_flags"},  bad,    0);
    chk({tag, "_data"},   got_d,  ed);
    chk({tag, "_sat"},    got_s,  es);
  endtask

  // Interrupt a computation while it sits in state D, by clr or by reset.
  task automatic run_abort(input string tag, input int sp, input int m, input bit use_reset);
    int pulses;
    drive_sample(sp, m, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (use_reset) rstn = 1'b0;
    else           bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    rstn    = 1'b1;
    m_acc   = 0;
    m_eprev = 0;
    pulses  = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    chk({tag, "_no_out"}, pulses, 0);
    chk({tag, "_ready"},  bus.in_ready, 1);
    chk({tag, "_busy"},   bus.busy, 0);
    if (use_reset) begin
      chk({tag, "_data0"}, bus.out_data, 0);
      chk({tag, "_sat0"},  bus.sat, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
    bus.meas     = '0;
    bus.setpoint = '0;
    bus.kp       = '0;
    bus.ki       = '0;
    bus.kd       = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_sat",       bus.sat,       0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_in_ready",  bus.in_ready,  1);

    g_kp = 256; g_ki = 0; g_kd = 0;
    run_sample("p_only", 2000, 1000, 0, 1, 1000, 0);
    run_sample("p_neg",  1000, 2000, 0, 0, 0, 1);
    g_kp = 2048;
    run_sample("p_hi",   3000, 0,    0, 0, 4095, 1);

    g_kp = 0; g_ki = 128; g_kd = 0;
    run_sample("i_1", 600, 500, 0, 1, 50,  0);
    run_sample("i_2", 600, 500, 0, 0, 100, 0);
    run_sample("i_3", 600, 500, 0, 0, 150, 0);
    run_sample("i_clr", 600, 500, 0, 1, 50, 0);

    g_kp = 0; g_ki = 0; g_kd = 256;
    run_sample("d_1", 600, 500, 0, 1, 100, 0);
    run_sample("d_2", 600, 500, 0, 0, 0,   0);
    run_sample("d_3", 540, 500, 0, 0, 0,   1);

    g_kp = 0; g_ki = 128; g_kd = 0;
    run_sample("busy_drop", 600, 500, 1, 1, 50,  0);
    run_sample("busy_next", 600, 500, 0, 0, 100, 0);

    run_abort("clr_abort", 600, 500, 0);
    run_sample("after_clr", 600, 500, 0, 0, 50, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        g_kp = int'($urandom_range(0, 1024)) - 512;
        g_ki = int'($urandom_range(0, 256)) - 128;
        g_kd = int'($urandom_range(0, 1024)) - 512;
      end else begin
        g_kp = int'($signed(16'($urandom)));
        g_ki = int'($signed(16'($urandom)));
        g_kd = int'($signed(16'($urandom)));
      end
      run_sample("rand", int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                 0, ($urandom_range(0, 7) == 0), -1, 0);
    end

    g_kp = 256; g_ki = 0; g_kd = 0;
    run_sample("pre_rst", 2000, 1000, 0, 1, 1000, 0);
    run_abort("rst_abort", 600, 500, 1);
    g_kp = 0; g_ki = 128; g_kd = 256;
    run_sample("after_rst", 600, 500, 0, 0, 150, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
